// File: rtl/regfile_sb.sv
// Integer register file with same-cycle writeback bypass and a busy-bit
// scoreboard tracking outstanding writes claimed by decode.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*AW-1:0]     rs,
    output logic [NREAD*XLEN-1:0]   rs_out,
    output logic [NREAD-1:0]        rs_busy,
    input  logic [AW-1:0]           rd,
    input  logic [XLEN-1:0]         write_val,
    input  logic                    write_enable,
    input  logic [AW-1:0]           rsv_rd,
    input  logic                    rsv_enable,
    output logic [AW:0]             rsv_count,
    output logic                    busy_any,
    output logic                    waw_err
);
    localparam int NREGS = 2**AW;

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             waw_q, waw_d;

    logic eff_wr, eff_rsv, same_reg, inc, dec;

    always_comb begin
        eff_wr   = write_enable && !((ZERO_REG != 0) && (rd == '0));
        eff_rsv  = rsv_enable && !((ZERO_REG != 0) && (rsv_rd == '0));
        same_reg = (rd == rsv_rd);

        // A write and reserve of the same busy register is a hand-over: count holds.
        inc = eff_rsv && !busy_q[rsv_rd];
        dec = eff_wr && busy_q[rd] && !(eff_rsv && same_reg);

        busy_d = busy_q;
        if (eff_wr)
            busy_d[rd] = 1'b0;
        if (eff_rsv)
            busy_d[rsv_rd] = 1'b1;

        cnt_d = cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
        waw_d = waw_q || (eff_rsv && busy_q[rsv_rd] && !(eff_wr && same_reg));

        mem_d = mem_q;
        if (eff_wr)
            mem_d[rd] = write_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                mem_q[i] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
            waw_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            waw_q  <= waw_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_rd
            logic [AW-1:0] addr;
            logic          zero_hit;
            logic          wr_hit;

            assign addr     = rs[gi*AW +: AW];
            assign zero_hit = (ZERO_REG != 0) && (addr == '0);
            assign wr_hit   = eff_wr && (rd == addr);

            assign rs_out[gi*XLEN +: XLEN] = zero_hit ? '0 :
                                             wr_hit   ? write_val :
                                                        mem_q[addr];
            // Register 0 never gets reserved with ZERO_REG, so its busy bit stays 0.
            assign rs_busy[gi] = busy_q[addr] && !wr_hit;
        end
    endgenerate

    assign rsv_count = cnt_q;
    assign busy_any  = (cnt_q != '0);
    assign waw_err   = waw_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a driver pushes predicted outputs per
// cycle, a negedge monitor pops and compares against the DUT.
module tb_regfile_sb;
    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREAD = 2;
    localparam int NREGS = 32;

    logic                  clk;
    logic                  rst;
    logic [NREAD*AW-1:0]   rs;
    logic [NREAD*XLEN-1:0] rs_out;
    logic [NREAD-1:0]      rs_busy;
    logic [AW-1:0]         rd;
    logic [XLEN-1:0]       write_val;
    logic                  write_enable;
    logic [AW-1:0]         rsv_rd;
    logic                  rsv_enable;
    logic [AW:0]           rsv_count;
    logic                  busy_any;
    logic                  waw_err;

    regfile_sb #(.XLEN(XLEN), .AW(AW), .NREAD(NREAD), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rs(rs), .rs_out(rs_out), .rs_busy(rs_busy),
        .rd(rd), .write_val(write_val), .write_enable(write_enable),
        .rsv_rd(rsv_rd), .rsv_enable(rsv_enable), .rsv_count(rsv_count),
        .busy_any(busy_any), .waw_err(waw_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NREAD*XLEN-1:0] out;
        logic [NREAD-1:0]      busy;
        logic [AW:0]           cnt;
        logic                  any;
        logic                  waw;
        int                    id;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   next_id = 0;

    // Reference model: plain arrays describing the architectural state.
    logic [XLEN-1:0] m_mem  [NREGS];
    bit              m_busy [NREGS];
    bit              m_waw;

    function automatic void model_clear();
        for (int r = 0; r < NREGS; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
        m_waw = 1'b0;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        int   a;
        int   pop;
        bit   we_eff;
        we_eff = write_enable && (rd != 0);
        for (int i = 0; i < NREAD; i++) begin
            a = int'(rs[i*AW +: AW]);
            if (a == 0)
                e.out[i*XLEN +: XLEN] = '0;
            else if (we_eff && int'(rd) == a)
                e.out[i*XLEN +: XLEN] = write_val;
            else
                e.out[i*XLEN +: XLEN] = m_mem[a];
            e.busy[i] = m_busy[a] && !(we_eff && int'(rd) == a);
        end
        pop = 0;
        for (int r = 0; r < NREGS; r++)
            pop += int'(m_busy[r]);
        e.cnt = (AW+1)'(pop);
        e.any = (pop != 0);
        e.waw = m_waw;
        e.id  = next_id;
        return e;
    endfunction

    function automatic void model_edge();
        bit we_eff, re_eff, waw_hit;
        if (rst)
            return;
        we_eff  = write_enable && (rd != 0);
        re_eff  = rsv_enable && (rsv_rd != 0);
        waw_hit = re_eff && m_busy[rsv_rd] && !(we_eff && rd == rsv_rd);
        if (we_eff) begin
            m_mem[rd]  = write_val;
            m_busy[rd] = 1'b0;
        end
        if (re_eff)
            m_busy[rsv_rd] = 1'b1;
        if (waw_hit)
            m_waw = 1'b1;
    endfunction

    function automatic logic [NREAD*AW-1:0] pk(input int a0, input int a1);
        return {AW'(a1), AW'(a0)};
    endfunction

    task automatic step(input logic [NREAD*AW-1:0] a, input int wrd, input logic [XLEN-1:0] wv,
                        input logic we, input int rrd, input logic re);
        rs           = a;
        rd           = AW'(wrd);
        write_val    = wv;
        write_enable = we;
        rsv_rd       = AW'(rrd);
        rsv_enable   = re;
        sb_q.push_back(predict());
        next_id++;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic async_reset();
        #2;
        rst          = 1'b1;
        write_enable = 1'b0;
        rsv_enable   = 1'b0;
        model_clear();
        sb_q.push_back(predict());
        next_id++;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s txn=%0d actual=%h required=%h", name, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("rs_out",    e.id, 64'(rs_out),    64'(e.out));
            chk("rs_busy",   e.id, 64'(rs_busy),   64'(e.busy));
            chk("rsv_count", e.id, 64'(rsv_count), 64'(e.cnt));
            chk("busy_any",  e.id, 64'(busy_any),  64'(e.any));
            chk("waw_err",   e.id, 64'(waw_err),   64'(e.waw));
            $display("txn %0d rst=%0b rs=%h rs_out=%h rs_busy=%b cnt=%0d waw=%0b",
                     e.id, rst, rs, rs_out, rs_busy, rsv_count, waw_err);
        end
    end

    initial begin
        rst          = 1'b1;
        rs           = '0;
        rd           = '0;
        write_val    = '0;
        write_enable = 1'b0;
        rsv_rd       = '0;
        rsv_enable   = 1'b0;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset contents on every register, both ports.
        for (int i = 0; i < NREGS / 2; i++)
            step(pk(2*i, 2*i + 1), 0, '0, 1'b0, 0, 1'b0);

        // Bypass, array read-back, hardwired zero.
        step(pk(5, 5), 5, 32'hDEADBEEF, 1'b1, 0, 1'b0);
        step(pk(5, 0), 0, '0, 1'b0, 0, 1'b0);
        step(pk(0, 5), 0, 32'h1234, 1'b1, 0, 1'b0);
        step(pk(0, 5), 0, '0, 1'b0, 0, 1'b0);

        // Reservation visible next cycle, cleared by writeback (with bypass).
        step(pk(7, 1), 0, '0, 1'b0, 7, 1'b1);
        step(pk(7, 1), 0, '0, 1'b0, 0, 1'b0);
        step(pk(7, 7), 7, 32'h55, 1'b1, 0, 1'b0);
        step(pk(7, 1), 0, '0, 1'b0, 0, 1'b0);

        // WAW error is sticky until reset.
        step(pk(3, 0), 0, '0, 1'b0, 3, 1'b1);
        step(pk(3, 0), 0, '0, 1'b0, 3, 1'b1);
        step(pk(3, 0), 0, '0, 1'b0, 0, 1'b0);
        async_reset();
        step(pk(3, 0), 0, '0, 1'b0, 0, 1'b0);

        // Same-edge write and reserve of a busy register: hand-over, no error.
        step(pk(9, 0), 0, '0, 1'b0, 9, 1'b1);
        step(pk(9, 9), 9, 32'hABCD, 1'b1, 9, 1'b1);
        step(pk(9, 0), 0, '0, 1'b0, 0, 1'b0);

        // Reservations discarded by an asynchronous reset mid-cycle.
        step(pk(1, 2), 0, '0, 1'b0, 1, 1'b1);
        step(pk(1, 2), 0, '0, 1'b0, 2, 1'b1);
        step(pk(1, 3), 0, '0, 1'b0, 3, 1'b1);
        async_reset();
        step(pk(1, 3), 0, '0, 1'b0, 0, 1'b0);

        // Randomized traffic, with occasional resets to re-arm waw_err.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0)
                async_reset();
            else
                step(pk(int'($urandom_range(0, NREGS-1)), int'($urandom_range(0, NREGS-1))),
                     int'($urandom_range(0, NREGS-1)), XLEN'($urandom),
                     1'($urandom_range(0, 1)),
                     int'($urandom_range(0, NREGS-1)),
                     ($urandom_range(0, 9) < 3));
        end
        write_enable = 1'b0;
        rsv_enable   = 1'b0;

        for (int k = 0; k < 10 && sb_q.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with per-register scoreboard, for the pipelined core's decode/writeback stages. Provides NREAD combinational read ports with same-cycle writeback bypass, one write port, and a hardwired-zero x0 option. A busy-bit scoreboard is set by decode when an instruction claims rd and cleared by writeback. This gives per-read-port hazard flags, an outstanding-write count, and a sticky WAW error flag.

## Interface

- XLEN, 32, data width in bits
- AW, 5, register address width; NREGS = 2**AW
- NREAD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes/reservations; 0: register 0 is ordinary

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rs  in  NREAD*AW  read addresses; port i at [i*AW +: AW]
- rs_out  out  NREAD*XLEN  read data; port i at [i*XLEN +: XLEN]
- rs_busy  out  NREAD  port i source has an outstanding reservation
- rd  in  AW  writeback address
- write_val  in  XLEN  writeback data
- write_enable  in  1  writeback strobe
- rsv_rd  in  AW  reservation address (from decode)
- rsv_enable  in  1  reservation strobe
- rsv_count  out  AW+1  number of busy registers
- busy_any  out  1  rsv_count != 0
- waw_err  out  1  sticky: reservation made on an already-busy register

## Operation

- State: NREGS×XLEN array, NREGS busy bits, rsv_count register, waw_err register.
- Reset (rst=1, async): all array entries 0, all busy 0, rsv_count 0, waw_err 0. rs_out is therefore 0 and rs_busy is 0 on every port; busy_any is 0. Reset mid-operation discards all pending reservations.
- "Effective write": write_enable=1 and not (ZERO_REG and rd=0). "Effective reserve": rsv_enable=1 and not (ZERO_REG and rsv_rd=0).
- Write, on the edge:
  - An effective write stores write_val to array[rd].
  - It clears busy[rd] unless the same edge reserves rd.
  - Writing a non-busy register is legal and leaves the busy bits unchanged.
- Reserve, on the edge:
  - An effective reserve sets busy[rsv_rd].
  - If busy[rsv_rd] was already 1 and the same edge does not effectively write rsv_rd, waw_err is set to 1. It stays 1 until reset.
- Simultaneous write and reserve to the same register: the data is stored, busy ends at 1 and rsv_count is unchanged. This is the new producer taking over the register and is not a WAW error.
- rsv_count is always equal to the population count of the busy bits. It is updated incrementally: +1 for a reserve of a not-busy register, -1 for a write that clears a busy bit.
- Read port i, combinational, in priority order:
  - ZERO_REG and rs_i=0: output 0.
  - Effective write with rd=rs_i: output write_val (bypass).
  - Otherwise: output array[rs_i].
- rs_busy[i] = busy[rs_i] AND NOT (effective write with rd=rs_i). With ZERO_REG, register 0 is never busy.
- Reservation does not bypass: a register reserved this cycle reads busy from the next cycle on.

## Timing

- Read latency 0 cycles: rs_out and rs_busy are combinational from rs, rd, write_enable, write_val and state.
- A write is visible via bypass in the same cycle, and from the array from the next cycle.
- busy, rsv_count, busy_any and waw_err change only on the clock edge or on asserted rst; they are glitch-free registered values. busy_any is decoded from the registered count.
- Inputs are X-tolerant while rst=1.

## Test plan

- Reset then read all 32 registers on both ports -> rs_out=0, rs_busy=0, rsv_count=0, busy_any=0, waw_err=0.
- Write 0xDEADBEEF to r5 and read r5 in the same cycle -> rs_out=0xDEADBEEF (bypass). Next cycle with write_enable=0 -> still 0xDEADBEEF. Write 0x1234 to r0 -> r0 reads 0 (ZERO_REG=1).
- Reserve r7, next cycle read r7 -> rs_busy=1, rsv_count=1. Write r7=0x55 while reading it -> rs_busy=0, rs_out=0x55. After the edge -> rsv_count=0.
- Reserve r3, then reserve r3 again with no writeback -> waw_err=1 after the second edge, rsv_count=1. Assert rst -> waw_err=0.
- Write r9 and reserve r9 on the same edge while r9 is busy -> value stored, r9 still busy, rsv_count unchanged, waw_err=0.
- Reserve r1, r2, r3 on consecutive cycles, then assert rst asynchronously between edges -> rsv_count=0, busy_any=0 and all rs_busy=0 immediately, before the next clk edge.
